// File: rtl/samp_pkg.sv
// Shared I/Q sample type used by the sample FIFO and the decimator.
package samp_pkg;

    localparam int unsigned SAMP_W = 24;

    typedef struct packed {
        logic signed [SAMP_W-1:0] I;
        logic signed [SAMP_W-1:0] Q;
    } Samp;

endpackage

// File: rtl/samp_acc_rail.sv
// One accumulator rail: sums sign-extended samples and yields the floor-shifted average on dump.
module samp_acc_rail
    import samp_pkg::*;
#(
    parameter int unsigned LOG2_DECIM = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     add,
    input  logic                     dump,
    input  logic signed [SAMP_W-1:0] sample,
    output logic signed [SAMP_W-1:0] avg_c
);

    localparam int unsigned ACC_W = SAMP_W + LOG2_DECIM;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum_c;
    logic signed [ACC_W-1:0] shifted_c;

    // Extra LOG2_DECIM headroom bits make a full group unable to overflow.
    assign sum_c     = acc + ACC_W'(sample);
    assign shifted_c = sum_c >>> LOG2_DECIM;
    assign avg_c     = shifted_c[SAMP_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear || (add && dump)) begin
            acc <= '0;
        end else if (add) begin
            acc <= sum_c;
        end
    end

endmodule

// File: rtl/samp_decimator.sv
// Integrate-and-dump decimator: pulls I/Q samples from the FIFO and emits one average per DECIM.
module samp_decimator
    import samp_pkg::*;
#(
    parameter int unsigned DECIM      = 4,
    parameter int unsigned LOG2_DECIM = $clog2(DECIM)
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  Samp                   fifo_samp,
    input  logic                  fifo_empty,
    output logic                  fifo_PullOut,
    input  logic                  Clear,
    input  logic                  StopIn,
    output logic                  PushOut,
    output Samp                   DecSamp,
    output logic [LOG2_DECIM-1:0] GroupCnt
);

    localparam logic [LOG2_DECIM-1:0] LAST_CNT = LOG2_DECIM'(DECIM - 1);

    logic                     slot_free_c;
    logic                     last_c;
    logic                     pull_c;
    logic                     dump_c;
    logic signed [SAMP_W-1:0] avg_i_c;
    logic signed [SAMP_W-1:0] avg_q_c;

    // The final sample of a group may only be pulled when the output slot frees this cycle.
    assign slot_free_c  = !PushOut || !StopIn;
    assign last_c       = (GroupCnt == LAST_CNT);
    assign pull_c       = Reset_n && !fifo_empty && !Clear && (!last_c || slot_free_c);
    assign dump_c       = pull_c && last_c;
    assign fifo_PullOut = pull_c;

    samp_acc_rail #(.LOG2_DECIM(LOG2_DECIM)) u_rail_i (
        .clk    (Clk),
        .rst_n  (Reset_n),
        .clear  (Clear),
        .add    (pull_c),
        .dump   (dump_c),
        .sample (fifo_samp.I),
        .avg_c  (avg_i_c)
    );

    samp_acc_rail #(.LOG2_DECIM(LOG2_DECIM)) u_rail_q (
        .clk    (Clk),
        .rst_n  (Reset_n),
        .clear  (Clear),
        .add    (pull_c),
        .dump   (dump_c),
        .sample (fifo_samp.Q),
        .avg_c  (avg_q_c)
    );

    // Group counter; Clear restarts the group without touching a pending output.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            GroupCnt <= '0;
        end else if (Clear) begin
            GroupCnt <= '0;
        end else if (pull_c) begin
            GroupCnt <= last_c ? '0 : GroupCnt + LOG2_DECIM'(1);
        end
    end

    // Output register; a dump on a transfer edge reloads it with no bubble.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            PushOut <= 1'b0;
            DecSamp <= '0;
        end else if (dump_c) begin
            PushOut   <= 1'b1;
            DecSamp.I <= avg_i_c;
            DecSamp.Q <= avg_q_c;
        end else if (PushOut && !StopIn) begin
            PushOut <= 1'b0;
        end
    end

endmodule
